// File: rtl/hs_rr_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hs_rr_arbiter_if
//  Brief    : N-to-1 valid/ready bundle shared by hs_rr_arbiter and its users.
//  Revision : 1.0  initial release
// ============================================================================
interface hs_rr_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int DATA_WD = 4
);
    localparam int ID_WD = $clog2(N_REQ);

    logic [N_REQ-1:0]         valid_in;
    logic [N_REQ*DATA_WD-1:0] data_in;
    logic [N_REQ-1:0]         ready_in;
    logic                     valid_out;
    logic [DATA_WD-1:0]       data_out;
    logic [ID_WD-1:0]         id_out;
    logic                     ready_out;

    // master: the producers/consumer around the arbiter; slave: the arbiter
    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, id_out
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, id_out
    );
endinterface

`default_nettype wire

// File: rtl/hs_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hs_rr_arbiter
//  Brief    : Round-robin N-to-1 valid/ready arbiter with output-stability lock.
//             Define HS_RR_ARB_SKID_EN for a registered 2-entry skid output.
//  Revision : 1.0  initial release
// ============================================================================
module hs_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_WD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    hs_rr_arbiter_if.slave bus
);
    localparam int               ID_WD     = $clog2(N_REQ);
    localparam logic [ID_WD-1:0] c_last_id = ID_WD'(N_REQ - 1);

    logic [ID_WD-1:0] ptr_q, ptr_d;
    logic [ID_WD-1:0] w_win;
    logic             w_any_valid;
    int               w_dist;
    int               w_best_dist;

    function automatic logic [ID_WD-1:0] next_id(input logic [ID_WD-1:0] id);
        return (id == c_last_id) ? '0 : id + ID_WD'(1);
    endfunction

    function automatic logic [DATA_WD-1:0] pick_data(input logic [ID_WD-1:0]         id,
                                                     input logic [N_REQ*DATA_WD-1:0] d);
        logic [DATA_WD-1:0] r;
        r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (id == ID_WD'(k)) r = d[k*DATA_WD +: DATA_WD];
        end
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [ID_WD-1:0] id);
        logic [N_REQ-1:0] r;
        r = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (id == ID_WD'(k)) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Winner is the valid requester at the smallest circular distance from ptr.
    always_comb begin : p_rr_search
        w_win       = '0;
        w_best_dist = N_REQ;
        w_dist      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (k >= int'(ptr_q)) w_dist = k - int'(ptr_q);
            else                  w_dist = k + N_REQ - int'(ptr_q);
            if (bus.valid_in[k] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_win       = ID_WD'(k);
            end
        end
    end

    assign w_any_valid = |bus.valid_in;

`ifdef HS_RR_ARB_SKID_EN
    logic               main_vld_q, main_vld_d;
    logic               skid_vld_q, skid_vld_d;
    logic [DATA_WD-1:0] main_data_q, main_data_d;
    logic [DATA_WD-1:0] skid_data_q, skid_data_d;
    logic [ID_WD-1:0]   main_id_q, main_id_d;
    logic [ID_WD-1:0]   skid_id_q, skid_id_d;
    logic               w_arb_fire;
    logic               w_out_fire;
    logic [DATA_WD-1:0] w_win_data;

    // The arbiter only sees the buffer, so ready_in never depends on ready_out.
    assign w_win_data = pick_data(w_win, bus.data_in);
    assign w_arb_fire = w_any_valid & ~skid_vld_q;
    assign w_out_fire = main_vld_q & bus.ready_out;

    always_comb begin : p_buf_next
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_id_d   = main_id_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_id_d   = skid_id_q;
        ptr_d       = ptr_q;
        if (w_arb_fire) ptr_d = next_id(w_win);

        if (w_out_fire || !main_vld_q) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = skid_data_q;
                main_id_d   = skid_id_q;
                skid_vld_d  = 1'b0;
            end else if (w_arb_fire) begin
                main_vld_d  = 1'b1;
                main_data_d = w_win_data;
                main_id_d   = w_win;
            end else begin
                main_vld_d  = 1'b0;
            end
        end else if (w_arb_fire) begin
            skid_vld_d  = 1'b1;
            skid_data_d = w_win_data;
            skid_id_d   = w_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_buf_regs
        if (!rst_n) begin
            ptr_q       <= '0;
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_id_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_id_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_id_q   <= main_id_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_id_q   <= skid_id_d;
        end
    end

    assign bus.valid_out = main_vld_q;
    assign bus.data_out  = main_data_q;
    assign bus.id_out    = main_id_q;
    assign bus.ready_in  = one_hot(w_win) & {N_REQ{w_arb_fire & rst_n}};
`else
    localparam logic [1:0] c_st_arb  = 2'd0;
    localparam logic [1:0] c_st_hold = 2'd1;

    logic [1:0]       state_q, state_d;
    logic [ID_WD-1:0] lock_id_q, lock_id_d;
    logic [ID_WD-1:0] w_sel;
    logic             w_valid;
    logic             w_fire;

    always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            state_q   <= c_st_arb;
            lock_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin : p_next_state
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        case (state_q)
            c_st_arb: begin
                if (w_any_valid && !bus.ready_out) begin
                    state_d   = c_st_hold;
                    lock_id_d = w_win;
                end
            end
            c_st_hold: begin
                if (bus.ready_out) state_d = c_st_arb;
            end
            default: state_d = c_st_arb;
        endcase
        if (w_fire) ptr_d = next_id(w_sel);
    end

    // While held, the locked requester stays selected whatever else arrives.
    always_comb begin : p_outputs
        w_sel   = w_win;
        w_valid = w_any_valid;
        if (state_q == c_st_hold) begin
            w_sel   = lock_id_q;
            w_valid = 1'b1;
        end
    end

    assign w_fire        = w_valid & bus.ready_out & rst_n;
    assign bus.valid_out = w_valid & rst_n;
    assign bus.data_out  = rst_n ? pick_data(w_sel, bus.data_in) : '0;
    assign bus.id_out    = rst_n ? w_sel : '0;
    assign bus.ready_in  = one_hot(w_sel) & {N_REQ{w_valid & bus.ready_out & rst_n}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_hs_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hs_rr_arbiter
//  Brief    : Randomised scoreboard bench for hs_rr_arbiter (both builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hs_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int IW = $clog2(N);
`ifdef HS_RR_ARB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct {
        int             id;
        logic [DW-1:0]  data;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hs_rr_arbiter_if #(.N_REQ(N), .DATA_WD(DW)) bus  ();
    hs_rr_arbiter_if #(.N_REQ(3), .DATA_WD(DW)) bus3 ();

    hs_rr_arbiter #(.N_REQ(N), .DATA_WD(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hs_rr_arbiter #(.N_REQ(3), .DATA_WD(DW)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Producer state and reference model
    logic [N-1:0]  v;
    logic [DW-1:0] pl [N];
    int            seq [N];
    bit            fixed_pl;
    int            m_ptr;
    int            m_lock_id;
    int            m_cnt;
    bit            m_lock;
    beat_t         exp_q [$];
    logic [N-1:0]  exp_ready;
    logic          exp_vout;
    bit            rec_en;
    int            rec_ids [$];
    int            rec3 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic int rr_first(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[IW'((ptr + i) % N)]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic clear_model();
        v         = '0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_id = 0;
        m_cnt     = 0;
        exp_q.delete();
        exp_ready = '0;
        exp_vout  = 1'b0;
        bus.valid_in   = '0;
        bus.data_in    = '0;
        bus.ready_out  = 1'b0;
        bus3.valid_in  = '0;
        bus3.data_in   = '0;
        bus3.ready_out = 1'b0;
    endtask

    // One clock: raise requested producers, drive, and predict this cycle.
    task automatic step(input logic [N-1:0] want, input bit r);
        int g;
        bit acc;
        bit ofire;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!v[k] && want[k]) begin
                v[k]  = 1'b1;
                pl[k] = fixed_pl ? DW'(10 + k) : DW'(seq[k]);
                seq[k]++;
            end
        end
        bus.valid_in = v;
        for (int k = 0; k < N; k++) bus.data_in[k*DW +: DW] = pl[k];
        bus.ready_out = r;

        g = m_lock ? m_lock_id : rr_first(v, m_ptr);
`ifdef HS_RR_ARB_SKID_EN
        exp_vout = (m_cnt > 0);
        acc      = (g >= 0) && (m_cnt < 2);
        ofire    = (m_cnt > 0) && r;
        m_cnt    = m_cnt + int'(acc) - int'(ofire);
`else
        ofire    = 1'b0;
        exp_vout = (g >= 0);
        acc      = (g >= 0) && r;
        m_lock   = (g >= 0) && !r && !ofire;
        if (m_lock) m_lock_id = g;
`endif
        exp_ready = '0;
        if (acc) begin
            exp_ready[IW'(g)] = 1'b1;
            exp_q.push_back('{id: g, data: pl[IW'(g)]});
            v[IW'(g)] = 1'b0;
            m_ptr     = (g + 1) % N;
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        clear_model();
        #20;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares DUT outputs against the scoreboard on every falling edge.
    initial begin : monitor
        bit             pv;
        logic [IW-1:0]  pid;
        logic [DW-1:0]  pdata;
        int             wait_cnt [N];
        logic [N-1:0]   fin;
        beat_t          e;
        pv = 1'b0;
        pid = '0;
        pdata = '0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                for (int k = 0; k < N; k++) wait_cnt[k] = 0;
            end else begin
                check("ready_in", 32'(bus.ready_in), 32'(exp_ready));
                check("valid_out", 32'(bus.valid_out), 32'(exp_vout));
                if (pv) check("hold_stable", {bus.valid_out, bus.id_out, bus.data_out}, {1'b1, pid, pdata});
                if (bus.valid_out && bus.ready_out) begin
                    check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat_id_data", {bus.id_out, bus.data_out}, {IW'(e.id), e.data});
                    end
                    if (rec_en && rec_ids.size() < 8) rec_ids.push_back(int'(bus.id_out));
                end
                fin = bus.valid_in & bus.ready_in;
                for (int k = 0; k < N; k++) begin
                    if (fin[k]) begin
                        check("no_starve", 32'(wait_cnt[k] <= N - 1), 32'd1);
                        wait_cnt[k] = 0;
                    end else if (bus.valid_in[k] && fin != '0) begin
                        wait_cnt[k]++;
                    end
                end
                pv    = bus.valid_out && !bus.ready_out;
                pid   = bus.id_out;
                pdata = bus.data_out;
                if (bus3.valid_out && bus3.ready_out) rec3.push_back(int'(bus3.id_out));
            end
        end
    end

    initial begin : stimulus
        for (int k = 0; k < N; k++) begin
            seq[k] = 0;
            pl[k]  = '0;
        end
        rec_en   = 1'b0;
        fixed_pl = 1'b1;
        clear_model();

        // Reset with all requesters active: outputs must stay quiet
        bus.valid_in  = '1;
        bus.data_in   = 16'hDCBA;
        bus.ready_out = 1'b1;
        #100;
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_ready_in", 32'(bus.ready_in), 32'd0);
        check("rst_id_out", 32'(bus.id_out), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        clear_model();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // All requesters valid, downstream always ready: strict rotation from 0
        rec_en = 1'b1;
        step('1, 1'b1);
        @(negedge clk);
        check("t2_first_valid", 32'(bus.valid_out), SKID ? 32'd0 : 32'd1);
        repeat (7) step('1, 1'b1);
        repeat (N + 4) step('0, 1'b1);
        rec_en = 1'b0;
        check("t2_count", rec_ids.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rec_ids.size()) check("t2_id", rec_ids[i], i % N);
        end

        // Stall on requester 2 while requester 0 arrives
        do_reset();
        fixed_pl = 1'b0;
        step(4'b0100, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0101, 1'b0);
        @(negedge clk);
        check("t3_id_held", 32'(bus.id_out), 32'd2);
        check("t3_valid_held", 32'(bus.valid_out), 32'd1);
        check("t3_ready0_low", 32'(bus.ready_in[0]), 32'd0);
        repeat (6) step('0, 1'b1);
        check("t3_drained", exp_q.size(), 0);

        // Three requesters: pointer wraps to 0 after requester 2 fires
        bus3.ready_out = 1'b1;
        step('0, 1'b1);
        bus3.valid_in = 3'b100;
        bus3.data_in  = 12'h321;
        @(negedge clk);
        check("t4_grant2", 32'(bus3.ready_in), 32'b100);
        step('0, 1'b1);
        bus3.valid_in = 3'b101;
        @(negedge clk);
        check("t4_grant0", 32'(bus3.ready_in), 32'b001);
        step('0, 1'b1);
        bus3.valid_in = 3'b100;
        @(negedge clk);
        check("t4_grant2_again", 32'(bus3.ready_in), 32'b100);
        step('0, 1'b1);
        bus3.valid_in = '0;
        repeat (3) step('0, 1'b1);
        check("t4_count", rec3.size(), 3);
        if (rec3.size() == 3) begin
            check("t4_order0", rec3[0], 2);
            check("t4_order1", rec3[1], 0);
            check("t4_order2", rec3[2], 2);
        end

        // Random traffic with back-pressure
        do_reset();
        repeat (500) step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
        repeat (20) step('0, 1'b1);
        check("t5_drained", exp_q.size(), 0);

        // Reset while an offered beat is stalled
        repeat (2) step('1, 1'b1);
        repeat (3) step('1, 1'b0);
        #2;
        check("t6_pre_valid", 32'(bus.valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_valid_out", 32'(bus.valid_out), 32'd0);
        check("t6_ready_in", 32'(bus.ready_in), 32'd0);
        clear_model();
        #20;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step('1, 1'b1);
        @(negedge clk);
        check("t6_first_grant", 32'(bus.ready_in), 32'b0001);
        repeat (N + 6) step('0, 1'b1);
        check("t6_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
